// File: rtl/kbd_rx_ctrl_pkg.sv
// kbd_rx_ctrl_pkg: shared FSM encoding, status-register bit positions and count saturation helper
package kbd_rx_ctrl_pkg;
  typedef enum logic [1:0] {
    KS_IDLE    = 2'd0,
    KS_CAPTURE = 2'd1,
    KS_RELEASE = 2'd2
  } kbd_state_t;
  localparam int KBD_STAT_EMPTY   = 0;
  localparam int KBD_STAT_FULL    = 1;
  localparam int KBD_STAT_CNT_LSB = 2;
  localparam int KBD_STAT_OVF     = 6;
  localparam int KBD_STAT_IRQEN   = 15;
  function automatic logic [3:0] sat_cnt(input logic [7:0] c);
    return c > 8'd15 ? 4'd15 : c[3:0];
  endfunction
endpackage

// File: rtl/kbd_rx_ctrl_fifo.sv
// kbd_sync_fifo: 8-bit synchronous FIFO with wrap-bit pointers; a pop frees room for a same-cycle push
module kbd_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_pop, do_push;
  assign empty   = wr_ptr == rd_ptr;
  assign full    = wr_ptr[AW-1:0] == rd_ptr[AW-1:0] && wr_ptr[AW] != rd_ptr[AW];
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  always_ff @(posedge clk)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/kbd_rx_ctrl.sv
// kbd_rx_ctrl: PS/2 adapter handshake FSM, key-code FIFO and CPU data/status registers with irq
module kbd_rx_ctrl
  import kbd_rx_ctrl_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int AW         = $clog2(DEPTH),
  parameter bit IRQ_EN_RST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_ready,
  input  logic [7:0]  key_ascii,
  output logic        key_receive,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic        bus_sel,
  input  logic [15:0] bus_wdata,
  output logic [15:0] bus_rdata,
  output logic        irq
);
  kbd_state_t  state;
  logic [7:0]  code, head;
  logic        full, empty, ovf, irq_en, push, pop;
  logic [AW:0] count;
  logic [15:0] stat;
  logic [14:0] wdata_unused;
  assign wdata_unused = bus_wdata[15:1];
  assign push = state == KS_CAPTURE && code != 8'h00;
  assign pop  = bus_rd & ~bus_sel;
  always_comb begin
    stat = '0;
    stat[KBD_STAT_EMPTY] = empty;
    stat[KBD_STAT_FULL] = full;
    stat[KBD_STAT_CNT_LSB +: 4] = sat_cnt(8'(count));
    stat[KBD_STAT_OVF] = ovf;
    stat[KBD_STAT_IRQEN] = irq_en;
  end
  kbd_sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(code),
    .head(head), .full(full), .empty(empty), .count(count)
  );
  // key_receive is registered from the next state so the adapter sees it low from CAPTURE onward
  always_ff @(posedge clk)
    if (!rst) begin
      state <= KS_IDLE;
      code <= 8'h00;
      key_receive <= 1'b0;
    end else
      case (state)
        KS_IDLE:
          if (key_ready) begin
            code <= key_ascii;
            state <= KS_CAPTURE;
            key_receive <= 1'b0;
          end else key_receive <= 1'b1;
        KS_CAPTURE: begin
          state <= KS_RELEASE;
          key_receive <= 1'b0;
        end
        KS_RELEASE:
          if (!key_ready) begin
            state <= KS_IDLE;
            key_receive <= 1'b1;
          end
        default: begin
          state <= KS_IDLE;
          key_receive <= 1'b0;
        end
      endcase
  always_ff @(posedge clk)
    if (!rst) begin
      ovf <= 1'b0;
      irq_en <= IRQ_EN_RST;
      bus_rdata <= '0;
      irq <= 1'b0;
    end else begin
      if (bus_rd) bus_rdata <= bus_sel ? stat : (empty ? 16'h0000 : {8'h00, head});
      ovf <= (push & full & ~pop) | (ovf & ~(bus_rd & bus_sel));
      if (bus_wr & bus_sel & ~bus_rd) irq_en <= bus_wdata[0];
      irq <= irq_en & ~empty;
    end
endmodule

// File: tb/tb_kbd_rx_ctrl.sv
// tb_kbd_rx_ctrl: queue-based reference model feeding a read scoreboard, directed plus random key/bus traffic
module tb_kbd_rx_ctrl;
  localparam int DEPTH = 8;
  logic clk = 0, rst = 0, key_ready = 0, bus_rd = 0, bus_wr = 0, bus_sel = 0;
  logic [7:0] key_ascii = 0;
  logic [15:0] bus_wdata = 0;
  logic key_receive, irq;
  logic [15:0] bus_rdata;
  int tests = 0, fails = 0;
  bit done = 0;
  always #5 clk = ~clk;
  kbd_rx_ctrl #(.DEPTH(DEPTH), .AW(3), .IRQ_EN_RST(1'b1)) dut (
    .clk(clk), .rst(rst), .key_ready(key_ready), .key_ascii(key_ascii),
    .key_receive(key_receive), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .irq(irq)
  );
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: the FIFO is a plain queue; a key press is taken once per ready-high episode
  byte unsigned q[$];
  logic [15:0] sb[$];
  bit m_ovf, m_irq_en = 1, m_irq, m_kr, armed = 1, cap_pend, rd_valid;
  byte unsigned cap_code;
  always @(posedge clk) begin : model
    int n;
    bit popping, new_cap, armed_new;
    if (!rst) begin
      q.delete();
      m_ovf = 0; m_irq_en = 1; m_irq = 0; m_kr = 0;
      armed = 1; cap_pend = 0; rd_valid = 0;
    end else begin
      n = q.size();
      popping = bus_rd && !bus_sel && n > 0;
      rd_valid = bus_rd;
      if (bus_rd)
        sb.push_back(bus_sel ? {m_irq_en, 8'b0, m_ovf, 4'(n > 15 ? 15 : n), n == DEPTH, n == 0}
                             : (n > 0 ? {8'h00, q[0]} : 16'h0000));
      m_irq = m_irq_en && n > 0;
      if (bus_rd && bus_sel) m_ovf = 0;
      if (popping) void'(q.pop_front());
      if (cap_pend && cap_code != 0) begin
        if (n < DEPTH || popping) q.push_back(cap_code);
        else m_ovf = 1;
      end
      if (bus_wr && bus_sel && !bus_rd) m_irq_en = bus_wdata[0];
      new_cap = armed && key_ready;
      armed_new = !key_ready && (armed || !cap_pend);
      if (new_cap) cap_code = key_ascii;
      cap_pend = new_cap;
      armed = armed_new;
      m_kr = armed;
    end
  end
  always @(negedge clk)
    if (rst) begin
      chk("irq", 16'(irq), 16'(m_irq));
      chk("key_receive", 16'(key_receive), 16'(m_kr));
      if (rd_valid) begin
        if (sb.size() == 0) chk("sb_empty", 16'(sb.size()), 16'd1);
        else chk("rdata", bus_rdata, sb.pop_front());
      end
    end
  task automatic rd(input bit sel);
    bus_rd = 1; bus_sel = sel;
    @(negedge clk);
    bus_rd = 0;
  endtask
  task automatic press(input logic [7:0] c, input int hold, input int gap);
    key_ascii = c; key_ready = 1;
    repeat (hold) @(negedge clk);
    key_ready = 0; key_ascii = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rdata", bus_rdata, 16'h0000);
    chk("rst_irq", 16'(irq), 16'h0);
    chk("rst_krecv", 16'(key_receive), 16'h0);
    rst = 1;
    @(negedge clk);
    chk("idle_krecv", 16'(key_receive), 16'h1);
    rd(1); chk("idle_stat", bus_rdata, 16'h8001);
    press(8'h61, 50, 2);
    rd(0); chk("data_a", bus_rdata, 16'h0061);
    rd(1); chk("stat_after_a", bus_rdata, 16'h8001);
    for (int i = 0; i < 9; i++) press(8'h31 + 8'(i), 4, 2);
    rd(1); chk("stat_ovf", bus_rdata, 16'h8062);
    rd(1); chk("stat_ovf_clr", bus_rdata, 16'h8022);
    key_ascii = 8'h41; key_ready = 1;
    @(negedge clk);
    bus_rd = 1; bus_sel = 0;
    @(negedge clk);
    bus_rd = 0;
    chk("pop_on_capture", bus_rdata, 16'h0031);
    repeat (3) @(negedge clk);
    key_ready = 0;
    repeat (2) @(negedge clk);
    rd(1); chk("stat_full_swap", bus_rdata, 16'h8022);
    for (int i = 0; i < 8; i++) begin
      rd(0); chk("drain", bus_rdata, i == 7 ? 16'h0041 : 16'h0032 + 16'(i));
    end
    rd(0); chk("empty_read", bus_rdata, 16'h0000);
    key_ascii = 8'h00; key_ready = 1;
    repeat (3) @(negedge clk);
    chk("zero_krecv", 16'(key_receive), 16'h0);
    key_ready = 0;
    repeat (2) @(negedge clk);
    rd(1); chk("zero_stat", bus_rdata, 16'h8001);
    press(8'h55, 4, 3);
    bus_wr = 1; bus_sel = 1; bus_wdata = 16'h0000;
    @(negedge clk);
    bus_wr = 0;
    chk("irq_before_fall", 16'(irq), 16'h1);
    @(negedge clk);
    chk("irq_fall", 16'(irq), 16'h0);
    key_ascii = 8'h66; key_ready = 1;
    repeat (4) @(negedge clk);
    rst = 0; key_ready = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rd(1); chk("stat_after_rst", bus_rdata, 16'h8001);
    fork
      begin
        for (int i = 0; i < 30; i++)
          press($urandom_range(0, 4) == 0 ? 8'h00 : 8'($urandom_range(1, 255)),
                $urandom_range(3, 8), $urandom_range(1, 4));
        done = 1;
      end
      begin
        while (!done) begin
          int r;
          r = $urandom_range(0, 99);
          bus_wdata = 16'($urandom);
          bus_wdata[0] = $urandom_range(0, 3) != 0;
          if (r < 30) begin bus_rd = 1; bus_sel = 0; end
          else if (r < 42) begin bus_rd = 1; bus_sel = 1; end
          else if (r < 48) begin bus_wr = 1; bus_sel = 1; end
          else if (r < 52) begin bus_rd = 1; bus_wr = 1; bus_sel = 1; end
          else if (r < 55) begin bus_wr = 1; bus_sel = 0; end
          @(negedge clk);
          bus_rd = 0; bus_wr = 0;
        end
      end
    join
    repeat (3) @(negedge clk);
    chk("sb_drained", 16'(sb.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/kbd_rx_ctrl.md
Name: kbd_rx_ctrl

Overview:
Controller between the PS/2 keyboard adapter and the CPU memory-mapped IO bus. It sequences the adapter's level-type ready/receive handshake and turns each key press into exactly one accepted ASCII code. Accepted codes are buffered in a small FIFO. The CPU reads a data register (pops the FIFO) and a status register (empty/full/overflow/count), and an interrupt request is raised while data is pending.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..64
AW, 3, log2(DEPTH)
IRQ_EN_RST, 1, reset value of the interrupt-enable bit

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
key_ready  in  1  adapter DataReady; level, high while a key is held and unacknowledged
key_ascii  in  8  adapter ASCII output; valid while key_ready=1
key_receive  out  1  to adapter DataReceive; low clears the adapter's ready latch
bus_rd  in  1  CPU read strobe, one cycle
bus_wr  in  1  CPU write strobe, one cycle
bus_sel  in  1  0 = data register, 1 = status/control register
bus_wdata  in  16  write data (only bit 0 used: irq_en)
bus_rdata  out  16  read data, registered
irq  out  1  interrupt request

Behaviour:
- Reset (rst=0 at posedge): FSM to IDLE; FIFO empty; ovf=0; irq_en=IRQ_EN_RST; key_receive=0; bus_rdata=0; irq=0.
- Handshake FSM, 3 states:
  - IDLE: key_receive=1. If key_ready=1, sample key_ascii and go to CAPTURE.
  - CAPTURE, one cycle: push the sampled code. Drop it if code==0 (unmapped key). If the FIFO is full, drop it and set ovf. Go to RELEASE.
  - RELEASE: key_receive=0. Stay until key_ready=0, then go to IDLE.
  - Result: one push per key press, no auto-repeat. Total latency from key_ready rising to FIFO count increment is 2 cycles.
- FIFO: pointers AW+1 bits wide with a wrap bit. empty = ptrs equal; full = addresses equal and wrap bits differ. count = wr_ptr - rd_ptr, width AW+1.
- Data read (bus_rd, bus_sel=0):
  - Next cycle, bus_rdata = {8'h00, head}, then the head pops.
  - If the FIFO is empty, bus_rdata = 16'h0000 and there is no pop; this is not an error.
- Status read (bus_rd, bus_sel=1): next cycle bus_rdata = {irq_en, 8'b0, ovf, count[AW:0] zero-extended to 4 bits, full, empty}.
  - Bit 15 = irq_en; bits 14:7 = 0; bit 6 = ovf; bits 5:2 = count; bit 1 = full; bit 0 = empty.
  - For DEPTH > 8, count is saturated at 15 in this field.
  - ovf clears on the same edge that registers the status read. If a new overflow occurs in that same cycle, ovf stays 1 (set wins).
- Control write (bus_wr, bus_sel=1): irq_en <= bus_wdata[0]. A write with bus_sel=0 is ignored.
- bus_rd and bus_wr both high in one cycle: the read executes and the write is ignored.
- No bus_rd: bus_rdata holds its previous value.
- Simultaneous push (CAPTURE) and pop on a full FIFO: the pop frees the slot, the push is accepted, and ovf is not set. Push and pop on an empty FIFO: the pop returns 0 and the push is stored.
- irq = irq_en & ~empty, registered (1-cycle lag after the FIFO state changes).
- rst going low mid-handshake: FSM returns to IDLE and key_receive goes low for the reset cycle. Any code in CAPTURE is discarded.

Decomposition:
- Shared package constants: KBD_STAT_EMPTY=0, KBD_STAT_FULL=1, KBD_STAT_CNT_LSB=2, KBD_STAT_OVF=6, KBD_STAT_IRQEN=15.
- Shared package FSM encoding: KS_IDLE=2'd0, KS_CAPTURE=2'd1, KS_RELEASE=2'd2.
- One sub-module, kbd_sync_fifo (DEPTH, 8-bit, push/pop/full/empty/count/head). The FSM and register file stay in kbd_rx_ctrl.

Test Plan:
- Reset then idle: bus_rdata=0, irq=0, key_receive=0 during reset and 1 after; a status read returns 16'h8001.
- Press 'a' (key_ascii=8'h61, key_ready held 50 cycles then released): exactly one push (count=1), irq=1 after 3 cycles; a data read returns 16'h0061, then status=16'h8001.
- Nine presses of 0x31..0x39 with DEPTH=8: the first eight are stored, the ninth is dropped. Status=16'h8062 (ovf=1, count=8 saturated into 4 bits as 8, full=1); the next status read shows ovf=0.
- Press with key_ascii=0: no push, count stays 0, key_receive still drops low until key_ready falls.
- FIFO full while a data read lands on the CAPTURE cycle: the head pops and the new code is accepted. Count stays 8 and ovf=0.
- Write control 16'h0000 with data pending: irq falls 1 cycle later. Drive reset during RELEASE: FIFO empty and FSM back in IDLE.
